// File: rtl/pwm_input_conditioner_if.sv
// Receiver-side bundle for the six-channel PWM input conditioner: raw pins in,
// clean levels, edge strobes and channel-valid flags out.
interface pwm_input_conditioner_if;
    logic [5:0] raw;
    logic [5:0] clean;
    logic [5:0] rise;
    logic [5:0] fall;
    logic [5:0] valid;
    logic       failsafe;

    modport master (output raw, input clean, rise, fall, valid, failsafe);
    modport slave  (input raw, output clean, rise, fall, valid, failsafe);
endinterface

// File: rtl/pwm_input_conditioner.sv
// Six-channel RC-receiver front end: 2-flop sync, glitch filter, rise/fall strobes.
// Optional per-channel signal-loss watchdog enabled by `define PWM_COND_WATCHDOG_EN.
module pwm_input_conditioner #(
    parameter int clockFreq     = 1000000,
    parameter int FILTER_CYCLES = 4,
    parameter int TIMEOUT_MS    = 50
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_pwm_0,
    input  logic       i_pwm_1,
    input  logic       i_pwm_2,
    input  logic       i_pwm_3,
    input  logic       i_pwm_4,
    input  logic       i_pwm_5,
    output logic       o_pwm_0,
    output logic       o_pwm_1,
    output logic       o_pwm_2,
    output logic       o_pwm_3,
    output logic       o_pwm_4,
    output logic       o_pwm_5,
    output logic [5:0] o_rise,
    output logic [5:0] o_fall,
    output logic [5:0] o_valid,
    output logic       o_failsafe
);
    localparam int NCH   = 6;
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [NCH-1:0]            raw;
    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            pwm_q, pwm_d;
    logic [NCH-1:0]            rise_q, rise_d;
    logic [NCH-1:0]            fall_q, fall_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    assign raw = {i_pwm_5, i_pwm_4, i_pwm_3, i_pwm_2, i_pwm_1, i_pwm_0};

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours (the sync chain depends on it).
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pwm_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            pwm_q   <= pwm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        pwm_d  = pwm_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < NCH; n++) begin
            if (sync2_q[n] == pwm_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_LAST) begin
                // FILTER_CYCLES consecutive disagreeing samples: accept the new level.
                pwm_d[n]  = sync2_q[n];
                cnt_d[n]  = '0;
                rise_d[n] = sync2_q[n];
                fall_d[n] = ~sync2_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
        end
    end

    assign o_pwm_0 = pwm_q[0];
    assign o_pwm_1 = pwm_q[1];
    assign o_pwm_2 = pwm_q[2];
    assign o_pwm_3 = pwm_q[3];
    assign o_pwm_4 = pwm_q[4];
    assign o_pwm_5 = pwm_q[5];
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

`ifdef PWM_COND_WATCHDOG_EN
    localparam int TIMEOUT_CYCLES = clockFreq / 1000 * TIMEOUT_MS;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [NCH-1:0][WD_W-1:0] wd_q, wd_d;
    logic [NCH-1:0]           valid_q, valid_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wd_q    <= '0;
            valid_q <= '0;
        end else begin
            wd_q    <= wd_d;
            valid_q <= valid_d;
        end
    end

    // Keyed on rise_d so the counter restarts on the same edge o_rise registers;
    // a rise on the timeout cycle therefore keeps the channel valid.
    always_comb begin
        wd_d    = wd_q;
        valid_d = valid_q;
        for (int n = 0; n < NCH; n++) begin
            if (rise_d[n]) begin
                wd_d[n]    = '0;
                valid_d[n] = 1'b1;
            end else if (wd_q[n] != WD_MAX) begin
                wd_d[n] = wd_q[n] + WD_W'(1);
                if (wd_d[n] == WD_MAX) valid_d[n] = 1'b0;
            end
        end
    end

    assign o_valid = valid_q;
`else
    // Timeout parameters are kept so both builds share one parameter list.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ((clockFreq / 1000 * TIMEOUT_MS) == 0);
    assign o_valid = '1;
`endif

    assign o_failsafe = ~&o_valid;

endmodule

// File: tb/tb_pwm_input_conditioner.sv
// Self-checking bench for pwm_input_conditioner: reset, table-driven pulses, random
// stimulus against a sample-window reference model, watchdog timing, mid-pulse reset.
module tb_pwm_input_conditioner;
    localparam int NCH    = 6;
    localparam int FILT   = 4;
    localparam int CLK_HZ = 1_000_000;
    localparam int TMO_MS = 5;
    localparam int TMO    = CLK_HZ / 1000 * TMO_MS;
    localparam int WIN    = FILT + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    pwm_input_conditioner_if bus ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_input_conditioner #(
        .clockFreq    (CLK_HZ),
        .FILTER_CYCLES(FILT),
        .TIMEOUT_MS   (TMO_MS)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rst_n),
        .i_pwm_0   (bus.raw[0]),
        .i_pwm_1   (bus.raw[1]),
        .i_pwm_2   (bus.raw[2]),
        .i_pwm_3   (bus.raw[3]),
        .i_pwm_4   (bus.raw[4]),
        .i_pwm_5   (bus.raw[5]),
        .o_pwm_0   (bus.clean[0]),
        .o_pwm_1   (bus.clean[1]),
        .o_pwm_2   (bus.clean[2]),
        .o_pwm_3   (bus.clean[3]),
        .o_pwm_4   (bus.clean[4]),
        .o_pwm_5   (bus.clean[5]),
        .o_rise    (bus.rise),
        .o_fall    (bus.fall),
        .o_valid   (bus.valid),
        .o_failsafe(bus.failsafe)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last FILT synchronized samples
    // (raw samples 2..FILT+1 edges old) all agree and differ from the output.
    typedef struct packed {
        logic [WIN-1:0][NCH-1:0] win;
        logic [NCH-1:0]          pwm;
        logic [NCH-1:0]          rise;
        logic [NCH-1:0]          fall;
        logic [NCH-1:0]          seen;
        logic [NCH-1:0]          valid;
        logic [NCH-1:0][31:0]    age;
    } model_t;

    function automatic model_t step(model_t m, logic [NCH-1:0] raw);
        model_t n;
        logic   all_hi, all_lo;
        n      = m;
        n.win  = {m.win[WIN-2:0], raw};
        n.rise = '0;
        n.fall = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            all_hi = 1'b1;
            all_lo = 1'b1;
            for (int k = 2; k < WIN; k++) begin
                all_hi &= n.win[k][ch];
                all_lo &= ~n.win[k][ch];
            end
            if (!m.pwm[ch] && all_hi) begin
                n.pwm[ch]  = 1'b1;
                n.rise[ch] = 1'b1;
            end else if (m.pwm[ch] && all_lo) begin
                n.pwm[ch]  = 1'b0;
                n.fall[ch] = 1'b1;
            end
            if (n.rise[ch]) begin
                n.age[ch]  = 0;
                n.seen[ch] = 1'b1;
            end else if (n.age[ch] < TMO) begin
                n.age[ch] = n.age[ch] + 1;
            end
            n.valid[ch] = n.seen[ch] && (n.age[ch] < TMO);
        end
        return n;
    endfunction

    model_t         mdl;
    logic [NCH-1:0] exp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= step(mdl, bus.raw);
    end

`ifdef PWM_COND_WATCHDOG_EN
    assign exp_valid = mdl.valid;
`else
    assign exp_valid = '1;
`endif

    always @(negedge clk) begin
        check("scoreboard",
              {bus.clean, bus.rise, bus.fall, bus.valid, bus.failsafe},
              {mdl.pwm, mdl.rise, mdl.fall, exp_valid, ~&exp_valid});
    end

    // Channel-3 watchdog monitor.
    logic mon_arm    = 1'b0;
    logic prev_v3    = 1'b0;
    logic gap_seen   = 1'b0;
    logic v_at_rise3 = 1'b0;
    int   last_rise3 = 0;
    int   gap        = 0;

    always @(negedge clk) begin
        prev_v3 <= bus.valid[3];
        if (bus.rise[3]) begin
            last_rise3 <= cyc;
            v_at_rise3 <= bus.valid[3];
        end
        if (!mon_arm) gap_seen <= 1'b0;
        else if (prev_v3 && !bus.valid[3]) begin
            gap      <= cyc - last_rise3;
            gap_seen <= 1'b1;
        end
    end

    task automatic run_periods(input int n, input logic [NCH-1:0] en);
        for (int p = 0; p < n; p++) begin
            bus.raw = en;
            repeat (150) @(negedge clk);
            bus.raw = '0;
            repeat (1850) @(negedge clk);
        end
    endtask

    typedef struct {
        int ch;
        int width;
        int exp_width;
        int exp_rises;
        int exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int             hi, rises, falls, lat;
        logic           others;
        logic [NCH-1:0] mask;
        int             hold[NCH];

        vecs[0] = '{1, 1500, 1500, 1, 6};
        vecs[1] = '{2,    3,    0, 0, 0};
        vecs[2] = '{2,    4,    4, 1, 6};
        vecs[3] = '{0,    1,    0, 0, 0};
        vecs[4] = '{5,    7,    7, 1, 6};
        vecs[5] = '{4,    2,    0, 0, 0};
        vecs[6] = '{3,   20,   20, 1, 6};

        // Reset held with random inputs.
        bus.raw = '0;
        repeat (6) begin
            @(negedge clk);
            bus.raw = NCH'($urandom);
        end
        @(negedge clk);
        check("reset_pwm",  bus.clean, 6'h00);
        check("reset_rise", bus.rise,  6'h00);
        check("reset_fall", bus.fall,  6'h00);
`ifdef PWM_COND_WATCHDOG_EN
        check("reset_valid",    bus.valid,    6'h00);
        check("reset_failsafe", bus.failsafe, 1'b1);
`else
        check("reset_valid",    bus.valid,    6'h3f);
        check("reset_failsafe", bus.failsafe, 1'b0);
`endif
        bus.raw = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven single pulses.
        foreach (vecs[v]) begin
            hi = 0; rises = 0; falls = 0; lat = 0; others = 1'b0;
            mask = NCH'(1 << vecs[v].ch);
            bus.raw[vecs[v].ch] = 1'b1;
            for (int i = 1; i <= vecs[v].width + 30; i++) begin
                @(negedge clk);
                if (bus.clean[vecs[v].ch] && lat == 0) lat = i;
                hi    += int'(bus.clean[vecs[v].ch]);
                rises += int'(bus.rise[vecs[v].ch]);
                falls += int'(bus.fall[vecs[v].ch]);
                others |= |((bus.clean | bus.rise | bus.fall) & ~mask);
                if (i == vecs[v].width) bus.raw[vecs[v].ch] = 1'b0;
            end
            check($sformatf("vec%0d_width", v),   64'(hi),    64'(vecs[v].exp_width));
            check($sformatf("vec%0d_rises", v),   64'(rises), 64'(vecs[v].exp_rises));
            check($sformatf("vec%0d_falls", v),   64'(falls), 64'(vecs[v].exp_rises));
            check($sformatf("vec%0d_latency", v), 64'(lat),   64'(vecs[v].exp_lat));
            check($sformatf("vec%0d_others", v),  64'(others), 64'(0));
        end

        // Random toggling with hold times around the filter length.
        foreach (hold[c]) hold[c] = $urandom_range(1, 10);
        repeat (4000) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    bus.raw[c] = ~bus.raw[c];
                    hold[c]    = $urandom_range(1, 10);
                end else begin
                    hold[c]--;
                end
            end
        end
        bus.raw = '0;
        repeat (20) @(negedge clk);

        // Watchdog: all channels pulsing, then channel 3 silent, then resumed.
        run_periods(3, 6'h3f);
        check("wd_all_valid",    bus.valid,    6'h3f);
        check("wd_all_failsafe", bus.failsafe, 1'b0);
        mon_arm = 1'b1;
        run_periods(3, 6'h37);
        mon_arm = 1'b0;
`ifdef PWM_COND_WATCHDOG_EN
        check("wd_lost_seen",     gap_seen,     1'b1);
        check("wd_lost_gap",      64'(gap),     64'(TMO));
        check("wd_lost_valid",    bus.valid,    6'h37);
        check("wd_lost_failsafe", bus.failsafe, 1'b1);
`else
        check("wd_lost_seen",     gap_seen,     1'b0);
        check("wd_lost_valid",    bus.valid,    6'h3f);
        check("wd_lost_failsafe", bus.failsafe, 1'b0);
`endif
        run_periods(1, 6'h3f);
        check("wd_resume_at_rise", v_at_rise3,   1'b1);
        check("wd_resume_valid",   bus.valid,    6'h3f);
        check("wd_resume_fs",      bus.failsafe, 1'b0);

        // Reset asserted mid-pulse with channel 0 held high.
        bus.raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_before", bus.clean[0], 1'b1);
        #2 rst_n = 1'b0;
        #1 check("midrst_async", bus.clean[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.clean[0] && lat == 0) lat = i;
            rises += int'(bus.rise[0]);
        end
        check("midrst_latency", 64'(lat),   64'(6));
        check("midrst_rises",   64'(rises), 64'(1));
        bus.raw = '0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
